// File: rtl/bcp_pkg.sv
// Shared widths, implication entry type and FSM state encoding for the BCP scan controller.
package bcp_pkg;

  localparam int NUM_CLAUSE   = 1023;
  localparam int NUM_VARIABLE = 128;
  localparam int CLAUSE_W     = $clog2(NUM_CLAUSE + 1);
  localparam int VAR_W        = $clog2(NUM_VARIABLE);

  typedef struct packed {
    logic [VAR_W-1:0] var_idx;
    logic             value;
  } impl_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } bcp_state_e;

endpackage

// File: rtl/bcp_impl_fifo.sv
// Synchronous implication queue with flush; head is presented from storage, never bypassed.
module bcp_impl_fifo
  import bcp_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clock_i,
  input  logic                       reset_n_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  impl_t                      push_data_i,
  input  logic                       pop_i,
  output impl_t                      head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  impl_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clock_i) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/bcp_scan_controller.sv
// Sequences one BCP pass over the clause store. Optional duplicate-implication filtering
// is built when BCP_DEDUP_EN is defined.
module bcp_scan_controller
  import bcp_pkg::*;
#(
  parameter int EVAL_LATENCY = 2,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic [CLAUSE_W-1:0] num_clause,
  output logic                busy,
  output logic                done,
  output logic                conflict,
  output logic [CLAUSE_W-1:0] conflict_clause,
  output logic                issue_valid,
  output logic [CLAUSE_W-1:0] issue_idx,
  input  logic                res_valid,
  input  logic                res_unit,
  input  logic [VAR_W-1:0]    res_var,
  input  logic                res_value,
  input  logic                res_false,
  output logic                impl_valid,
  input  logic                impl_ready,
  output logic [VAR_W-1:0]    impl_var,
  output logic                impl_value,
  output bcp_state_e          dbg_state_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // Handshakes: the datapath takes every issue_valid cycle (no back-pressure) and returns
  // res_valid exactly EVAL_LATENCY cycles later; an implication transfers on impl_valid & impl_ready.
  bcp_state_e          state_q, state_d;
  logic [CLAUSE_W-1:0] num_q, num_d;
  logic [CLAUSE_W-1:0] cnt_q, cnt_d;
  logic [CLAUSE_W-1:0] cclause_q, cclause_d;
  logic                conflict_q, conflict_d;
  logic [CNT_W-1:0]    inflight_q, inflight_d;
  logic [CLAUSE_W-1:0] idx_pipe_q [EVAL_LATENCY];

  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  impl_t               fifo_head;
  impl_t               push_data;

  logic res_live, res_retire, dup_same, dup_opp, push_unit, conflict_now;
  logic credit_ok, issue_fire, start_acc;

  // Results after a conflict are retired from the in-flight count but otherwise discarded.
  assign res_retire = res_valid && (inflight_q != '0);
  assign res_live   = res_retire && !conflict_q;
  assign start_acc  = (state_q == IDLE) && start;

`ifdef BCP_DEDUP_EN
  logic [NUM_VARIABLE-1:0] implied_q;
  logic [NUM_VARIABLE-1:0] polarity_q;

  assign dup_same = implied_q[res_var] && (polarity_q[res_var] == res_value);
  assign dup_opp  = implied_q[res_var] && (polarity_q[res_var] != res_value);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      implied_q  <= '0;
      polarity_q <= '0;
    end else if (start_acc) begin
      implied_q  <= '0;
      polarity_q <= '0;
    end else if (push_unit) begin
      implied_q[res_var]  <= 1'b1;
      polarity_q[res_var] <= res_value;
    end
  end
`else
  assign dup_same = 1'b0;
  assign dup_opp  = 1'b0;
`endif

  assign push_unit    = res_live && res_unit && !res_false && !dup_same && !dup_opp;
  assign conflict_now = res_live && (res_false || (res_unit && dup_opp));
  // Every in-flight result is reserved a queue slot, so a push can never overflow.
  assign credit_ok    = !fifo_full && ((int'(fifo_count) + int'(inflight_q) + 1) <= FIFO_DEPTH);
  assign issue_fire   = (state_q == ISSUE) && credit_ok && !conflict_now;

  always_comb begin
    inflight_d = inflight_q;
    if (issue_fire && !res_retire) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!issue_fire && res_retire) begin
      inflight_d = inflight_q - 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    cnt_d      = cnt_q;
    conflict_d = conflict_q;
    cclause_d  = cclause_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          num_d      = num_clause;
          cnt_d      = '0;
          conflict_d = 1'b0;
          state_d    = (num_clause == '0) ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        if (issue_fire) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == num_q - 1'b1) state_d = DRAIN;
        end
      end
      DRAIN:   if (inflight_d == '0) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (conflict_now) begin
      conflict_d = 1'b1;
      cclause_d  = idx_pipe_q[EVAL_LATENCY-1];
      if (state_q == ISSUE) state_d = DRAIN;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      num_q      <= '0;
      cnt_q      <= '0;
      conflict_q <= 1'b0;
      cclause_q  <= '0;
      inflight_q <= '0;
      for (int i = 0; i < EVAL_LATENCY; i++) idx_pipe_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      cnt_q      <= cnt_d;
      conflict_q <= conflict_d;
      cclause_q  <= cclause_d;
      inflight_q <= inflight_d;
      // Index delay line lines up with res_valid so the conflicting clause is exact.
      idx_pipe_q[0] <= cnt_q;
      for (int i = 1; i < EVAL_LATENCY; i++) idx_pipe_q[i] <= idx_pipe_q[i-1];
    end
  end

  assign push_data = '{var_idx: res_var, value: res_value};

  bcp_impl_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_impl_fifo (
    .clock_i     (clock),
    .reset_n_i   (reset_n),
    .flush_i     (conflict_now),
    .push_i      (push_unit),
    .push_data_i (push_data),
    .pop_i       (impl_ready),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign busy            = (state_q != IDLE);
  assign done            = (state_q == FINISH);
  assign conflict        = conflict_q;
  assign conflict_clause = cclause_q;
  assign issue_valid     = issue_fire;
  assign issue_idx       = cnt_q;
  assign impl_valid      = !fifo_empty;
  assign impl_var        = fifo_head.var_idx;
  assign impl_value      = fifo_head.value;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_bcp_scan_controller.sv
// Bench for bcp_scan_controller: fixed-latency datapath model, issue/implication scoreboards.
module tb_bcp_scan_controller;
  import bcp_pkg::*;

  localparam int L = 2;

  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  logic                start = 1'b0;
  logic [CLAUSE_W-1:0] num_clause = '0;
  logic                busy, done, conflict, issue_valid;
  logic [CLAUSE_W-1:0] conflict_clause, issue_idx;
  logic                res_valid = 1'b0, res_unit = 1'b0, res_value = 1'b0, res_false = 1'b0;
  logic [VAR_W-1:0]    res_var = '0;
  logic                impl_valid, impl_value;
  logic                impl_ready = 1'b0;
  logic [VAR_W-1:0]    impl_var;
  bcp_state_e          dbg_state;

  bcp_scan_controller #(.EVAL_LATENCY(L), .FIFO_DEPTH(8)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .num_clause(num_clause),
    .busy(busy), .done(done), .conflict(conflict), .conflict_clause(conflict_clause),
    .issue_valid(issue_valid), .issue_idx(issue_idx),
    .res_valid(res_valid), .res_unit(res_unit), .res_var(res_var),
    .res_value(res_value), .res_false(res_false),
    .impl_valid(impl_valid), .impl_ready(impl_ready),
    .impl_var(impl_var), .impl_value(impl_value), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  // clause table seen by the datapath model
  logic             cl_unit  [32];
  logic             cl_false [32];
  logic             cl_val   [32];
  logic [VAR_W-1:0] cl_var   [32];

  logic [CLAUSE_W-1:0] exp_issue_q[$];
  logic [VAR_W:0]      exp_impl_q[$];

  int n_checks = 0, n_bad = 0;
  int cyc = 0, iss_cnt = 0, done_cnt = 0, impl_seen = 0, first_iss = 0, last_iss = 0;

  logic                pv [L];
  logic [CLAUSE_W-1:0] pi [L];
  logic [CLAUSE_W-1:0] dp_idx, exp_i;
  logic [VAR_W:0]      exp_m;
  logic                dp_ok;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clock);
      #3;
    end
  endtask

  task automatic clear_table();
    for (int i = 0; i < 32; i++) begin
      cl_unit[i] = 1'b0; cl_false[i] = 1'b0; cl_val[i] = 1'b0; cl_var[i] = '0;
    end
    iss_cnt = 0; done_cnt = 0; impl_seen = 0;
  endtask

  task automatic push_issues(input int n);
    for (int i = 0; i < n; i++) exp_issue_q.push_back(CLAUSE_W'(i));
  endtask

  task automatic start_pass(input int n, output int took);
    num_clause = CLAUSE_W'(n);
    start = 1'b1;
    took = 0;
    do begin
      step(1);
      took++;
      start = 1'b0;
    end while (!done && took < 300);
    check_eq("done_seen", 32'(done), 32'd1);
  endtask

  // datapath model and output monitor: results L cycles after issue, scoreboard pops
  initial begin
    for (int i = 0; i < L; i++) begin pv[i] = 1'b0; pi[i] = '0; end
    forever begin
      @(negedge clock);
      cyc++;
      dp_idx    = pi[L-1];
      dp_ok     = pv[L-1] && (dp_idx < 32);
      res_valid = pv[L-1];
      res_unit  = dp_ok && cl_unit[dp_idx[4:0]];
      res_false = dp_ok && cl_false[dp_idx[4:0]];
      res_value = dp_ok && cl_val[dp_idx[4:0]];
      res_var   = dp_ok ? cl_var[dp_idx[4:0]] : '0;
      #4;
      for (int i = L - 1; i > 0; i--) begin pv[i] = pv[i-1]; pi[i] = pi[i-1]; end
      pv[0] = issue_valid && reset_n;
      pi[0] = issue_idx;
      if (issue_valid && reset_n) begin
        iss_cnt++;
        if (iss_cnt == 1) first_iss = cyc;
        last_iss = cyc;
        exp_i = (exp_issue_q.size() != 0) ? exp_issue_q.pop_front() : '1;
        check_eq("issue_idx", 32'(issue_idx), 32'(exp_i));
      end
      if (impl_valid) impl_seen++;
      if (impl_valid && impl_ready) begin
        exp_m = (exp_impl_q.size() != 0) ? exp_impl_q.pop_front() : '1;
        check_eq("impl_entry", 32'({impl_var, impl_value}), 32'(exp_m));
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int took;

  initial begin
    clear_table();
    step(3);
    // reset state
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_conflict", 32'(conflict), 32'd0);
    check_eq("rst_cclause", 32'(conflict_clause), 32'd0);
    check_eq("rst_issue_valid", 32'(issue_valid), 32'd0);
    check_eq("rst_issue_idx", 32'(issue_idx), 32'd0);
    check_eq("rst_impl_valid", 32'(impl_valid), 32'd0);
    check_eq("rst_impl_data", 32'({impl_var, impl_value}), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
    reset_n = 1'b1;
    step(2);

    // four plain clauses: back-to-back issues, done after 4+L+1 cycles
    clear_table();
    impl_ready = 1'b1;
    push_issues(4);
    start_pass(4, took);
    check_eq("t1_latency", took, 7);
    check_eq("t1_conflict", 32'(conflict), 32'd0);
    step(1);
    check_eq("t1_busy_after", 32'(busy), 32'd0);
    step(3);
    check_eq("t1_iss_cnt", iss_cnt, 4);
    check_eq("t1_iss_span", last_iss - first_iss, 3);
    check_eq("t1_impl_seen", impl_seen, 0);
    check_eq("t1_done_cnt", done_cnt, 1);

    // single unit clause stays queued after done until consumed
    clear_table();
    impl_ready = 1'b0;
    cl_unit[1] = 1'b1; cl_var[1] = 7'd5; cl_val[1] = 1'b1;
    push_issues(3);
    exp_impl_q.push_back({7'd5, 1'b1});
    start_pass(3, took);
    check_eq("t2_latency", took, 6);
    step(2);
    check_eq("t2_impl_valid", 32'(impl_valid), 32'd1);
    check_eq("t2_impl_var", 32'(impl_var), 32'd5);
    check_eq("t2_impl_value", 32'(impl_value), 32'd1);
    impl_ready = 1'b1;
    step(1);
    check_eq("t2_impl_gone", 32'(impl_valid), 32'd0);
    check_eq("t2_impl_left", exp_impl_q.size(), 0);

    // twenty unit clauses against a stalled consumer: credit limits issues to the queue depth
    clear_table();
    impl_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cl_unit[i] = 1'b1; cl_var[i] = VAR_W'(i + 10); cl_val[i] = i[0];
      exp_impl_q.push_back({VAR_W'(i + 10), i[0]});
    end
    push_issues(20);
    num_clause = CLAUSE_W'(20);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(30);
    check_eq("t3_iss_stall", iss_cnt, 8);
    check_eq("t3_impl_valid", 32'(impl_valid), 32'd1);
    check_eq("t3_busy", 32'(busy), 32'd1);
    impl_ready = 1'b1;
    step(1);
    impl_ready = 1'b0;
    step(10);
    check_eq("t3_iss_one_more", iss_cnt, 9);
    impl_ready = 1'b1;
    took = 0;
    while (!done && took < 300) begin step(1); took++; end
    check_eq("t3_done", 32'(done), 32'd1);
    step(20);
    check_eq("t3_issue_left", exp_issue_q.size(), 0);
    check_eq("t3_impl_left", exp_impl_q.size(), 0);
    check_eq("t3_conflict", 32'(conflict), 32'd0);

    // falsified clause 6: issuing stops, queue flushed, conflict reported
    clear_table();
    impl_ready = 1'b0;
    cl_unit[2] = 1'b1; cl_var[2] = 7'd20; cl_val[2] = 1'b1;
    cl_false[6] = 1'b1;
    cl_unit[8] = 1'b1; cl_var[8] = 7'd30;
    push_issues(L + 6);
    start_pass(10, took);
    check_eq("t4_latency", took, 11);
    check_eq("t4_conflict", 32'(conflict), 32'd1);
    check_eq("t4_cclause", 32'(conflict_clause), 32'd6);
    check_eq("t4_impl_flushed", 32'(impl_valid), 32'd0);
    check_eq("t4_impl_seen", impl_seen, 4);
    step(5);
    check_eq("t4_conflict_held", 32'(conflict), 32'd1);
    check_eq("t4_impl_still_0", 32'(impl_valid), 32'd0);
    check_eq("t4_iss_cnt", iss_cnt, 8);
    check_eq("t4_done_cnt", done_cnt, 1);
    check_eq("t4_issue_left", exp_issue_q.size(), 0);

    // empty pass; a start while busy is ignored
    clear_table();
    impl_ready = 1'b1;
    num_clause = '0;
    start = 1'b1;
    step(1);
    check_eq("t5_done", 32'(done), 32'd1);
    check_eq("t5_busy", 32'(busy), 32'd1);
    check_eq("t5_conflict_clr", 32'(conflict), 32'd0);
    num_clause = CLAUSE_W'(5);
    step(1);
    start = 1'b0;
    check_eq("t5_done_pulse", 32'(done), 32'd0);
    check_eq("t5_idle", 32'(busy), 32'd0);
    step(6);
    check_eq("t5_no_issue", iss_cnt, 0);
    check_eq("t5_done_cnt", done_cnt, 1);

`ifdef BCP_DEDUP_EN
    // repeated implication dropped, opposite polarity becomes a conflict
    clear_table();
    impl_ready = 1'b1;
    cl_unit[0] = 1'b1; cl_var[0] = 7'd9; cl_val[0] = 1'b1;
    cl_unit[2] = 1'b1; cl_var[2] = 7'd9; cl_val[2] = 1'b1;
    cl_unit[3] = 1'b1; cl_var[3] = 7'd9; cl_val[3] = 1'b0;
    push_issues(5);
    exp_impl_q.push_back({7'd9, 1'b1});
    start_pass(5, took);
    check_eq("t6_latency", took, 8);
    check_eq("t6_conflict", 32'(conflict), 32'd1);
    check_eq("t6_cclause", 32'(conflict_clause), 32'd3);
    step(3);
    check_eq("t6_impl_left", exp_impl_q.size(), 0);
    check_eq("t6_issue_left", exp_issue_q.size(), 0);
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
